// File: rtl/fpu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_ctrl_if
// Brief    : Request / FPU / response bundle between issue stage, controller and FPU.
// Revision : 1.0 - initial release
// ============================================================================
interface fpu_issue_ctrl_if #(
    parameter int BUS_WIDTH = 64,
    parameter int OP_LEN    = 5,
    parameter int TAG_W     = 5
);
    logic                 flush;
    logic                 req_valid;
    logic                 req_ready;
    logic [OP_LEN-1:0]    req_op;
    logic [BUS_WIDTH-1:0] req_in1;
    logic [BUS_WIDTH-1:0] req_in2;
    logic [TAG_W-1:0]     req_tag;
    logic [BUS_WIDTH-1:0] fpu_in1;
    logic [BUS_WIDTH-1:0] fpu_in2;
    logic [OP_LEN-1:0]    fpu_op;
    logic [BUS_WIDTH-1:0] fpu_out;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [BUS_WIDTH-1:0] rsp_data;
    logic [TAG_W-1:0]     rsp_tag;
    logic                 rsp_int_dest;
    logic                 rsp_illegal;
    logic                 busy;

    // Controller side
    modport slave (
        input  flush, req_valid, req_op, req_in1, req_in2, req_tag, fpu_out, rsp_ready,
        output req_ready, fpu_in1, fpu_in2, fpu_op, rsp_valid, rsp_data, rsp_tag,
               rsp_int_dest, rsp_illegal, busy
    );

    // Issue stage / FPU / consumer side
    modport master (
        output flush, req_valid, req_op, req_in1, req_in2, req_tag, fpu_out, rsp_ready,
        input  req_ready, fpu_in1, fpu_in2, fpu_op, rsp_valid, rsp_data, rsp_tag,
               rsp_int_dest, rsp_illegal, busy
    );
endinterface
`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_ctrl
// Brief    : Issue sequencer for a combinational FPU; holds operands for a
//            per-class latency and returns the tagged result.
//            Optional macro FPU_ILLEGAL_OP_CHECK_EN: opcodes 01110-11111 are
//            answered immediately with rsp_illegal=1 and rsp_data=0.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_issue_ctrl #(
    parameter int BUS_WIDTH = 64,
    parameter int OP_LEN    = 5,
    parameter int TAG_W     = 5,
    parameter int LAT_FAST  = 2,
    parameter int LAT_SLOW  = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fpu_issue_ctrl_if.slave  bus_io
);

    localparam int               CNT_W      = $clog2(LAT_SLOW + 1);
    localparam logic [CNT_W-1:0] c_cnt_fast = CNT_W'(LAT_FAST - 1);
    localparam logic [CNT_W-1:0] c_cnt_slow = CNT_W'(LAT_SLOW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic f_is_slow(input logic [OP_LEN-1:0] op);
        return (op == OP_LEN'(5'b00011)) || (op == OP_LEN'(5'b00100)) ||
               (op == OP_LEN'(5'b01100)) || (op == OP_LEN'(5'b01101));
    endfunction

    function automatic logic f_is_int_dest(input logic [OP_LEN-1:0] op);
        return (op == OP_LEN'(5'b00101)) || (op == OP_LEN'(5'b00111));
    endfunction

    function automatic logic f_is_single(input logic [OP_LEN-1:0] op);
        return (op >= OP_LEN'(5'b01001)) && (op <= OP_LEN'(5'b01101));
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] fpu_in1_q, fpu_in2_q, rsp_data_q;
    logic [OP_LEN-1:0]    fpu_op_q;
    logic [TAG_W-1:0]     rsp_tag_q;
    logic                 rsp_int_dest_q;

    logic                 w_req_ready;
    logic                 w_accept;
    logic                 w_illegal_req;
    logic                 w_capture;
    logic [BUS_WIDTH-1:0] w_result;

`ifdef FPU_ILLEGAL_OP_CHECK_EN
    logic                 rsp_illegal_q;
    assign w_illegal_req      = bus_io.req_op >= OP_LEN'(5'b01110);
    assign bus_io.rsp_illegal = rsp_illegal_q;
`else
    assign w_illegal_req      = 1'b0;
    assign bus_io.rsp_illegal = 1'b0;
`endif

    assign w_req_ready = (state_q == S_IDLE) && !bus_io.flush;
    assign w_accept    = bus_io.req_valid && w_req_ready;
    assign w_capture   = (state_q == S_EXEC) && (cnt_q == '0) && !bus_io.flush;

    // Single-precision results are NaN-boxed into the upper half.
    assign w_result = f_is_single(fpu_op_q) ?
                      {{(BUS_WIDTH-32){1'b1}}, bus_io.fpu_out[31:0]} : bus_io.fpu_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_illegal_req) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_EXEC;
                        cnt_d   = f_is_slow(bus_io.req_op) ? c_cnt_slow : c_cnt_fast;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (bus_io.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Flush overrides every transition, including the response handshake.
        if (bus_io.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_in1_q      <= '0;
            fpu_in2_q      <= '0;
            fpu_op_q       <= '0;
            rsp_data_q     <= '0;
            rsp_tag_q      <= '0;
            rsp_int_dest_q <= 1'b0;
`ifdef FPU_ILLEGAL_OP_CHECK_EN
            rsp_illegal_q  <= 1'b0;
`endif
        end else if (w_accept) begin
            fpu_in1_q      <= bus_io.req_in1;
            fpu_in2_q      <= bus_io.req_in2;
            fpu_op_q       <= bus_io.req_op;
            rsp_tag_q      <= bus_io.req_tag;
            rsp_int_dest_q <= f_is_int_dest(bus_io.req_op) && !w_illegal_req;
`ifdef FPU_ILLEGAL_OP_CHECK_EN
            rsp_illegal_q  <= w_illegal_req;
            if (w_illegal_req) begin
                rsp_data_q <= '0;
            end
`endif
        end else if (w_capture) begin
            rsp_data_q <= w_result;
        end
    end

    assign bus_io.req_ready    = w_req_ready;
    assign bus_io.fpu_in1      = fpu_in1_q;
    assign bus_io.fpu_in2      = fpu_in2_q;
    assign bus_io.fpu_op       = fpu_op_q;
    assign bus_io.rsp_valid    = (state_q == S_DONE);
    assign bus_io.rsp_data     = rsp_data_q;
    assign bus_io.rsp_tag      = rsp_tag_q;
    assign bus_io.rsp_int_dest = rsp_int_dest_q;
    assign bus_io.busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire
